// File: rtl/sramlike_defs.sv
// Shared encodings and bus payload type for the sram-like responders.
package sramlike_defs;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BADDR_W = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned CNT_W   = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Fibonacci taps 8,6,5,4 as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic               wr;
        logic [1:0]         size;
        logic [BADDR_W-1:0] addr;
        logic [DATA_W-1:0]  wdata;
    } req_t;

endpackage

// File: rtl/sramlike_data_responder_if.sv
// CPU data-side sram-like bus: request fields from the master, response from the slave.
interface sramlike_data_responder_if;
    import sramlike_defs::*;

    logic               req;
    logic               wr;
    logic [1:0]         size;
    logic [BADDR_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
    logic               addr_ok;
    logic               data_ok;
    logic [DATA_W-1:0]  rdata;
    logic               err;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );

endinterface

// File: rtl/sramlike_lane_mask.sv
// Access size + low address bits to byte enables; flags misaligned or reserved-size accesses.
module sramlike_lane_mask
    import sramlike_defs::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      addr_lo,
    output logic [BE_W-1:0] be_c,
    output logic            misalign_c
);

    always_comb begin
        be_c       = '0;
        misalign_c = 1'b0;
        case (size)
            SZ_BYTE: be_c = BE_W'(4'b0001 << addr_lo);
            SZ_HALF: begin
                if (addr_lo[0]) misalign_c = 1'b1;
                else            be_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                if (addr_lo != 2'b00) misalign_c = 1'b1;
                else                  be_c       = 4'b1111;
            end
            default: misalign_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/sramlike_data_responder.sv
// Data-side sram-like slave: one outstanding request, fixed latency, byte-enabled word memory.
// Optional pseudo-random acceptance stalls under SRAMLIKE_RANDOM_STALL_EN.
module sramlike_data_responder
    import sramlike_defs::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
)(
    input  logic                       clk,
    input  logic                       rst,
    sramlike_data_responder_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    req_t                req_q, req_d;
    logic                data_ok_q, data_ok_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    req_t                bus_req_c;
    req_t                cur_c;
    logic                gate_c;
    logic                addr_ok_c;
    logic                hs_c;
    logic                fire_c;
    logic                we_c;
    logic [BE_W-1:0]     be_c;
    logic                misalign_c;
    logic [ADDR_W-1:0]   idx_c;
    logic                unused_bits_c;

`ifdef SRAMLIKE_RANDOM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign gate_c        = ~lfsr_q[0];
    assign unused_bits_c = ^cur_c.addr[BADDR_W-1:ADDR_W+2];
`else
    assign gate_c        = 1'b1;
    assign unused_bits_c = ^{cur_c.addr[BADDR_W-1:ADDR_W+2], LFSR_SEED, LFSR_TAPS};
`endif

    assign bus_req_c = {bus.wr, bus.size, bus.addr, bus.wdata};
    assign addr_ok_c = (state_q == ST_IDLE) & bus.req & ~rst & gate_c;
    assign hs_c      = bus.req & addr_ok_c;

    // With LATENCY=1 the access happens on the handshake edge, so use the live bus fields
    assign cur_c  = (state_q == ST_WAIT) ? req_q : bus_req_c;
    assign fire_c = ~rst & (((state_q == ST_IDLE) & hs_c & (LATENCY == 1)) |
                            ((state_q == ST_WAIT) & (cnt_q == CNT_W'(1))));
    assign idx_c  = cur_c.addr[ADDR_W+1:2];
    assign we_c   = fire_c & cur_c.wr & ~misalign_c;

    sramlike_lane_mask u_lane_mask (
        .size       (cur_c.size),
        .addr_lo    (cur_c.addr[1:0]),
        .be_c       (be_c),
        .misalign_c (misalign_c)
    );

    // Next-state and response
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        data_ok_d = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (hs_c) begin
                    req_d = bus_req_c;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fire_c) begin
            data_ok_d = 1'b1;
            if (misalign_c) begin
                err_d   = 1'b1;
                rdata_d = '0;
            end else if (!cur_c.wr) begin
                rdata_d = mem_q[idx_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_c[b]) mem_q[idx_c][8*b +: 8] <= cur_c.wdata[8*b +: 8];
            end
        end
    end

    assign bus.addr_ok = addr_ok_c;
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_sramlike_data_responder.sv
// Directed bench for sramlike_data_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_sramlike_data_responder;
    import sramlike_defs::*;

    localparam int unsigned LAT2 = 2;

    logic clk;
    logic rst;

    sramlike_data_responder_if bus2();
    sramlike_data_responder_if bus1();

    sramlike_data_responder #(.ADDR_W(10), .LATENCY(LAT2), .LFSR_SEED(8'hA5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    sramlike_data_responder #(.ADDR_W(10), .LATENCY(1), .LFSR_SEED(8'hA5)) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd_g;
    logic        err_g;
    int          lat_g;
    logic        dok_after_g;

`ifdef SRAMLIKE_RANDOM_STALL_EN
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=2 port; call just after a rising edge
    task automatic xfer(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n;
        bus2.req = 1'b1; bus2.wr = w; bus2.size = sz; bus2.addr = a; bus2.wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
`ifdef SRAMLIKE_RANDOM_STALL_EN
            check_eq("stall_gate", 32'(bus2.addr_ok), 32'(!m_lfsr[0]));
`endif
        end while (!bus2.addr_ok && n < 50);
        check_eq("hs_seen", 32'(bus2.addr_ok), 32'd1);
        @(posedge clk);
        #1;
        // scramble fields after the handshake: only the handshake cycle counts
        bus2.req = 1'b0; bus2.wr = ~w; bus2.size = 2'd3; bus2.addr = 32'hFFFF_FFFF; bus2.wdata = 32'h0;
        lat_g = 0;
        do begin
            @(negedge clk);
            lat_g++;
        end while (!bus2.data_ok && lat_g < 20);
        rd_g  = bus2.rdata;
        err_g = bus2.err;
        @(negedge clk);
        dok_after_g = bus2.data_ok;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pat [4];
    logic [31:0] sb  [8];

    initial begin
        pat[0] = 32'hA0A0_0001; pat[1] = 32'hB1B1_0002;
        pat[2] = 32'hC2C2_0003; pat[3] = 32'hD3D3_0004;

        rst = 1'b1;
        bus2.req = 1'b1; bus2.wr = 1'b0; bus2.size = SZ_WORD; bus2.addr = '0; bus2.wdata = '0;
        bus1.req = 1'b0; bus1.wr = 1'b0; bus1.size = SZ_WORD; bus1.addr = '0; bus1.wdata = '0;

        // reset state, with req asserted to prove addr_ok is masked
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_addr_ok", 32'(bus2.addr_ok), 32'd0);
        check_eq("rst_data_ok", 32'(bus2.data_ok), 32'd0);
        check_eq("rst_rdata",   bus2.rdata,        32'd0);
        check_eq("rst_err",     32'(bus2.err),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus2.req = 1'b0;

        // word write/read, latency and one-cycle strobe
        xfer(1'b1, SZ_WORD, 32'h100, 32'hDEAD_BEEF);
        check_eq("sw_lat",    32'(lat_g),       32'(LAT2));
        check_eq("sw_err",    32'(err_g),       32'd0);
        check_eq("sw_pulse",  32'(dok_after_g), 32'd0);
        xfer(1'b0, SZ_WORD, 32'h100, 32'h0);
        check_eq("lw_lat",    32'(lat_g),       32'(LAT2));
        check_eq("lw_rdata",  rd_g,             32'hDEAD_BEEF);
        check_eq("lw_pulse",  32'(dok_after_g), 32'd0);

        // byte/half merges; rdata held across a write
        xfer(1'b1, SZ_WORD, 32'h200, 32'h0);
        check_eq("w_rdata_hold", rd_g, 32'hDEAD_BEEF);
        xfer(1'b1, SZ_BYTE, 32'h203, 32'h5A5A_5A5A);
        xfer(1'b1, SZ_HALF, 32'h200, 32'h1234_1234);
        xfer(1'b0, SZ_WORD, 32'h200, 32'h0);
        check_eq("merge_rdata", rd_g, 32'h5A00_1234);

        // aliasing: address bits above the index wrap
        xfer(1'b0, SZ_WORD, 32'h0000_1100, 32'h0);
        check_eq("alias_rdata", rd_g, 32'hDEAD_BEEF);

        // misaligned and reserved-size accesses
        xfer(1'b1, SZ_WORD, 32'h300, 32'h1122_3344);
        xfer(1'b1, SZ_HALF, 32'h301, 32'hFFFF_FFFF);
        check_eq("mis_sh_err",   32'(err_g), 32'd1);
        check_eq("mis_sh_rdata", rd_g,       32'd0);
        check_eq("mis_sh_lat",   32'(lat_g), 32'(LAT2));
        xfer(1'b0, SZ_WORD, 32'h300, 32'h0);
        check_eq("mis_keep",     rd_g,       32'h1122_3344);
        check_eq("mis_keep_err", 32'(err_g), 32'd0);
        xfer(1'b0, SZ_WORD, 32'h302, 32'h0);
        check_eq("mis_lw_err",   32'(err_g), 32'd1);
        check_eq("mis_lw_rdata", rd_g,       32'd0);
        xfer(1'b0, 2'd3, 32'h300, 32'h0);
        check_eq("sz3_err",      32'(err_g), 32'd1);
        xfer(1'b1, SZ_BYTE, 32'h301, 32'h7777_7777);
        xfer(1'b0, SZ_WORD, 32'h300, 32'h0);
        check_eq("sb_lane1",     rd_g,       32'h1122_7744);

        // reset right after a write handshake drops it
        xfer(1'b1, SZ_WORD, 32'h400, 32'h0102_0304);
        bus2.req = 1'b1; bus2.wr = 1'b1; bus2.size = SZ_WORD; bus2.addr = 32'h400; bus2.wdata = 32'hCAFE_F00D;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!bus2.addr_ok && n < 50);
            check_eq("rm_hs", 32'(bus2.addr_ok), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus2.req = 1'b0;
        @(negedge clk);
        check_eq("rm_dok0", 32'(bus2.data_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rm_dok1",  32'(bus2.data_ok), 32'd0);
        check_eq("rm_rdata", bus2.rdata,        32'd0);
        check_eq("rm_err",   32'(bus2.err),     32'd0);
        @(negedge clk);
        check_eq("rm_dok2",  32'(bus2.data_ok), 32'd0);
        @(posedge clk);
        #1;
        xfer(1'b0, SZ_WORD, 32'h400, 32'h0);
        check_eq("rm_prior", rd_g, 32'h0102_0304);

`ifndef SRAMLIKE_RANDOM_STALL_EN
        // back-to-back at LATENCY=1: writes then reads with req held high
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i <= 4; i++) begin
                if (i < 4) begin
                    bus1.req = 1'b1; bus1.wr = (pass == 0); bus1.size = SZ_WORD;
                    bus1.addr = 32'(16 * i); bus1.wdata = pat[i];
                end else begin
                    bus1.req = 1'b0;
                end
                @(negedge clk);
                if (i < 4) check_eq("b2b_aok", 32'(bus1.addr_ok), 32'd1);
                check_eq("b2b_dok", 32'(bus1.data_ok), (i > 0) ? 32'd1 : 32'd0);
                if (pass == 1 && i > 0) check_eq("b2b_rdata", bus1.rdata, pat[i-1]);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            check_eq("b2b_idle", 32'(bus1.data_ok), 32'd0);
            @(posedge clk);
            #1;
        end
`endif

        // randomised traffic against a scoreboard on a small window
        for (int k = 0; k < 8; k++) begin
            sb[k] = $urandom;
            xfer(1'b1, SZ_WORD, 32'h800 + 32'(4 * k), sb[k]);
            check_eq("rnd_init_lat", 32'(lat_g), 32'(LAT2));
        end
        for (int i = 0; i < 92; i++) begin
            int k;
            int ln;
            logic [7:0] b;
            k  = $urandom_range(0, 7);
            ln = $urandom_range(0, 3);
            b  = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    xfer(1'b0, SZ_WORD, 32'h800 + 32'(4 * k), 32'h0);
                    check_eq("rnd_rdata", rd_g, sb[k]);
                end
                1: begin
                    xfer(1'b1, SZ_BYTE, 32'h800 + 32'(4 * k + ln), {4{b}});
                    sb[k][8*ln +: 8] = b;
                end
                default: begin
                    sb[k] = $urandom;
                    xfer(1'b1, SZ_WORD, 32'h800 + 32'(4 * k), sb[k]);
                end
            endcase
            check_eq("rnd_lat", 32'(lat_g),       32'(LAT2));
            check_eq("rnd_err", 32'(err_g),       32'd0);
            check_eq("rnd_one", 32'(dok_after_g), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sramlike_data_responder.md
Name: sramlike_data_responder

Overview:
- Slave/responder end of the CPU data-side sram-like bus. The CPU-side translator drives request, byte address and lane-replicated write data onto this bus.
- Accepts one request at a time with an addr_ok handshake. Holds it for a programmable latency, then commits the write or samples the read into a word-organised byte-enabled memory, and returns data_ok with rdata.
- Used as the data memory model in the SoC testbench and as an on-chip scratch RAM.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2^ADDR_W 32-bit words, indexed by addr[ADDR_W+1:2].
- LATENCY, 2, cycles from the addr_ok handshake to data_ok; legal range 1..15.
- LFSR_SEED, 8'hA5, seed for the optional stall generator; must be nonzero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  access size: 0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- addr  in  32  byte address.
- wdata  in  32  write data, already lane-replicated by the master.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  one-cycle response strobe.
- rdata  out  32  full aligned word read; the master performs lane extraction.
- err  out  1  qualifies data_ok: the accepted request was misaligned or used size 3.

Behaviour:
- Reset values: addr_ok 0, data_ok 0, rdata 0, err 0, FSM in IDLE, counter 0. Memory contents are not reset.
- States:
  - IDLE: addr_ok = req & ~rst. A handshake occurs when req & addr_ok. On handshake, latch wr, size, addr, wdata; load counter = LATENCY-1; go to WAIT.
  - WAIT: addr_ok = 0. Decrement the counter each cycle. When the counter is 0 and the response fires, go to IDLE.
- Timing: for a handshake in cycle t, data_ok is high exactly in cycle t+LATENCY, for one cycle. The memory access is performed at the edge that raises data_ok.
  - LATENCY=1 skips the counting cycles: data_ok in t+1.
  - The FSM is in IDLE during the data_ok cycle, so a new handshake may coincide with data_ok (back-to-back).
- Byte enables from latched size and addr[1:0]:
  - byte: 0001, 0010, 0100 or 1000 selected by addr[1:0].
  - half: addr 00 → 0011; addr 10 → 1100.
  - word: addr 00 → 1111.
- Error case: misaligned access (half with addr[0]=1, word with addr[1:0]≠0) or size 3. No write, rdata 0, err=1 with data_ok.
- Write: each enabled byte of mem[idx] takes the matching byte of the latched wdata. rdata is held at its previous value.
- Read: rdata ← mem[idx] (whole word), registered. rdata is held until the next read response.
- err updates only on data_ok cycles and is otherwise 0.
- Reset mid-operation: the pending request is dropped, no write is committed, and no data_ok is issued.
- Master protocol violations (req drop or field change while addr_ok=0) are ignored. Only fields present on the handshake cycle matter.
- Address bits above ADDR_W+1 are ignored, so the memory aliases (wrap-around).

Optional Feature:
- Macro: SRAMLIKE_RANDOM_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is reset to LFSR_SEED and advances every cycle.
  - In IDLE, addr_ok is additionally gated by ~lfsr[0], injecting pseudo-random acceptance stalls.
  - Response latency after the handshake is unchanged.
- Undefined: no LFSR logic; addr_ok is purely req in IDLE.

Decomposition:
- Shared package/header sramlike_defs:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - state encoding ST_IDLE, ST_WAIT;
  - LFSR tap constant.
- One sub-module, sramlike_lane_mask: combinational size/addr[1:0] → 4-bit byte enable plus a misalign flag. It is reusable by the instruction-side responder.

Test Plan:
1. Word write then read, LATENCY=2: write addr 0x100 wdata 0xDEADBEEF, handshake cycle t → data_ok at t+2, err 0. Read 0x100 → rdata 0xDEADBEEF.
2. Byte/half writes on a word preset to 0x00000000:
   - SB addr 0x203, wdata 0x5A5A5A5A;
   - SH addr 0x200, wdata 0x12341234.
   - Read 0x200 → 0x5A001234.
3. Misaligned: SH at 0x301 with wdata 0xFFFFFFFF → data_ok with err=1. Subsequent read of 0x300 is unchanged; a read of 0x302 at word size gives err=1, rdata 0.
4. Back-to-back at LATENCY=1: req held high for 4 reads → addr_ok on 4 consecutive cycles, data_ok on the 4 following cycles, each one cycle after its handshake.
5. Reset mid-operation: a write to 0x400 of 0xCAFEF00D is accepted, and rst is pulsed in the next cycle → no data_ok, outputs 0. A later read of 0x400 returns the prior contents.
6. With SRAMLIKE_RANDOM_STALL_EN, LFSR_SEED 8'hA5: 100 random requests checked against a scoreboard → addr_ok has gaps matching ~lfsr[0], and every data_ok arrives exactly LATENCY cycles after its handshake.
